pixel_controller: RTL and testbench

Scan sequencer for the 8-digit seven-segment display. It time-multiplexes the display by stepping a 3-bit digit select through 0..7. That select drives the 8:1 4-bit address/data display mux. The block also drives the matching active-low anode enable. A blanking interval at the start of every digit slot suppresses ghosting while the mux output and segment decoder settle.

---
 rtl/pixel_controller.sv | 76 +++++++
 tb/tb_pixel_controller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_controller.sv
// Scan sequencer for an 8-digit seven-segment display: steps the digit select through 0..7
// and drives the matching active-low anode, with a blanking interval at each slot start.
module pixel_controller #(
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_en,
    input  logic [7:0] digit_en,
    output logic [2:0] seg_sel,
    output logic [7:0] anode,
    output logic       frame_done
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(TICK_DIV - 1);
    localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);

    typedef enum logic {
        StBlank,
        StDrive
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      seg_sel_q, seg_sel_d;
    logic [7:0]      anode_q, anode_d;
    logic            frame_done_q, frame_done_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        seg_sel_d    = seg_sel_q;
        anode_d      = 8'hFF;
        frame_done_d = 1'b0;

        if (!scan_en) begin
            cnt_d   = '0;
            state_d = StBlank;
        end else if (cnt_q == CntLast) begin
            // Slot end: the select only advances on the edge that darkens the display.
            cnt_d        = '0;
            state_d      = StBlank;
            seg_sel_d    = seg_sel_q + 3'd1;
            frame_done_d = (seg_sel_q == 3'd7);
        end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_d >= CntBlank) ? StDrive : StBlank;
            if (state_d == StDrive && digit_en[seg_sel_q]) begin
                anode_d = ~(8'h01 << seg_sel_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StBlank;
            cnt_q        <= '0;
            seg_sel_q    <= 3'd0;
            anode_q      <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seg_sel_q    <= seg_sel_d;
            anode_q      <= anode_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_sel    = seg_sel_q;
    assign anode      = anode_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_controller.sv
// Bench for pixel_controller with TICK_DIV = 8, BLANK_CYCLES = 2: table-driven scan vectors
// plus directed sequences for digit_en, scan_en and asynchronous reset corner cases.
module tb_pixel_controller;

    localparam int unsigned NumVec = 136;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scan_en = 1'b1;
    logic [7:0] digit_en = 8'hFF;
    logic [2:0] seg_sel;
    logic [7:0] anode;
    logic       frame_done;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       scan_en;
        logic [7:0] digit_en;
        logic [2:0] exp_seg;
        logic [7:0] exp_anode;
        logic       exp_fd;
    } vec_t;

    vec_t vecs[NumVec];

    pixel_controller #(
        .TICK_DIV    (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_en   (scan_en),
        .digit_en  (digit_en),
        .seg_sel   (seg_sel),
        .anode     (anode),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT just after reset release, with cnt = 0 and the next edge being edge 1.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Invariants sampled on the falling edge, away from the active edge.
    logic [2:0] prev_seg;
    logic       prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            chk("one_anode_low", 32'($countones(~anode) <= 1), 32'd1);
            if (prev_valid && seg_sel != prev_seg) begin
                chk("seg_change_while_lit", 32'(anode), 32'hFF);
            end
        end
        prev_seg   = seg_sel;
        prev_valid = !reset;
    end

    initial begin
        // Edge n after reset release: cnt = n % 8, slot = (n / 8) % 8.
        for (int i = 0; i < NumVec; i++) begin
            int         n;
            int         cnt;
            int         s;
            logic [7:0] de;
            logic [7:0] a;
            n   = i + 1;
            cnt = n % 8;
            s   = (n / 8) % 8;
            de  = (n <= 72) ? 8'hFF : 8'hFB;
            a   = 8'hFF;
            if (cnt >= 2 && de[s]) a = ~(8'h01 << s);
            vecs[i].scan_en   = 1'b1;
            vecs[i].digit_en  = de;
            vecs[i].exp_seg   = 3'(s);
            vecs[i].exp_anode = a;
            vecs[i].exp_fd    = (n % 64 == 0);
        end

        // Reset values
        do_reset();
        chk("reset_seg", 32'(seg_sel), 32'd0);
        chk("reset_anode", 32'(anode), 32'hFF);
        chk("reset_fd", 32'(frame_done), 32'd0);

        // Full scan with all digits, then a frame with digit 2 disabled
        for (int i = 0; i < NumVec; i++) begin
            scan_en  = vecs[i].scan_en;
            digit_en = vecs[i].digit_en;
            step();
            chk($sformatf("vec%0d_seg", i), 32'(seg_sel), 32'(vecs[i].exp_seg));
            chk($sformatf("vec%0d_anode", i), 32'(anode), 32'(vecs[i].exp_anode));
            chk($sformatf("vec%0d_fd", i), 32'(frame_done), 32'(vecs[i].exp_fd));
        end

        // Clear digit_en[3] at cycle 4 of slot 3
        scan_en  = 1'b1;
        digit_en = 8'hFF;
        do_reset();
        repeat (28) step();
        chk("d3_lit_seg", 32'(seg_sel), 32'd3);
        chk("d3_lit_anode", 32'(anode), 32'hF7);
        digit_en = 8'hF7;
        step();
        chk("d3_off_anode", 32'(anode), 32'hFF);
        chk("d3_off_seg", 32'(seg_sel), 32'd3);
        repeat (3) step();
        chk("slot4_start_seg", 32'(seg_sel), 32'd4);
        chk("slot4_start_anode", 32'(anode), 32'hFF);
        repeat (2) step();
        chk("slot4_drive_anode", 32'(anode), 32'hEF);

        // scan_en low mid-drive on digit 5, then re-enable
        digit_en = 8'hFF;
        do_reset();
        repeat (44) step();
        chk("d5_lit_anode", 32'(anode), 32'hDF);
        scan_en = 1'b0;
        step();
        chk("idle_anode", 32'(anode), 32'hFF);
        chk("idle_seg", 32'(seg_sel), 32'd5);
        chk("idle_fd", 32'(frame_done), 32'd0);
        repeat (3) step();
        chk("idle_hold_seg", 32'(seg_sel), 32'd5);
        chk("idle_hold_anode", 32'(anode), 32'hFF);
        scan_en = 1'b1;
        step();
        chk("resume_blank_anode", 32'(anode), 32'hFF);
        step();
        chk("resume_drive_anode", 32'(anode), 32'hDF);
        chk("resume_drive_seg", 32'(seg_sel), 32'd5);

        // Asynchronous reset between edges on digit 6
        do_reset();
        repeat (52) step();
        chk("d6_lit_anode", 32'(anode), 32'hBF);
        chk("d6_lit_seg", 32'(seg_sel), 32'd6);
        #2;
        reset = 1'b1;
        #1;
        chk("async_anode", 32'(anode), 32'hFF);
        chk("async_seg", 32'(seg_sel), 32'd0);
        chk("async_fd", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        chk("post_rst_blank_anode", 32'(anode), 32'hFF);
        step();
        chk("post_rst_drive_anode", 32'(anode), 32'hFE);
        chk("post_rst_seg", 32'(seg_sel), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
